// File: rtl/io_receiver_if.sv
// Feeder/core link bundle for io_receiver.
// slave = receiver view, master = feeder/core/bench view.
interface io_receiver_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int AW = $clog2(DEPTH);

  logic              intrpt;
  logic              cmd;
  logic [DATA_W-1:0] data_bus;
  logic              done;
  logic              proc_start;
  logic              proc_done;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [AW:0]       word_count;
  logic              overflow;
  logic              busy;

  modport slave (
    input  intrpt,
    input  cmd,
    input  data_bus,
    input  proc_done,
    input  rd_addr,
    output done,
    output proc_start,
    output rd_data,
    output word_count,
    output overflow,
    output busy
  );

  modport master (
    output intrpt,
    output cmd,
    output data_bus,
    output proc_done,
    output rd_addr,
    input  done,
    input  proc_start,
    input  rd_data,
    input  word_count,
    input  overflow,
    input  busy
  );
endinterface

// File: rtl/io_receiver.sv
// Chip-side feeder link: buffers LOAD words, acks them,
// and kicks the solver core on PROCESS.
module io_receiver #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input logic         clk,
  input logic         reset,
  io_receiver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    WAIT_REL,
    PROC_START,
    PROC_WAIT,
    FINISH,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       word_count;
  logic              overflow;
  logic              done_q;
  logic              start_q;
  logic              busy_q;
  logic              capture;
  logic              full;

  assign capture = (state == IDLE) && bus.intrpt && bus.cmd;
  assign full    = (word_count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.intrpt) begin
          state_d = bus.cmd ? ACK : PROC_START;
        end
      end
      ACK: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // feeder may switch to PROCESS without dropping intrpt
        if (!bus.intrpt) begin
          state_d = IDLE;
        end else if (!bus.cmd) begin
          state_d = PROC_START;
        end
      end
      PROC_START: begin
        state_d = PROC_WAIT;
      end
      PROC_WAIT: begin
        if (bus.proc_done) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!bus.intrpt) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs are flops decoded from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q  <= (state_d == ACK) || (state_d == FINISH);
      start_q <= (state_d == PROC_START);
      busy_q  <= (state_d == PROC_START) ||
                 (state_d == PROC_WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (state == FINISH) begin
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (capture) begin
      if (full) begin
        overflow <= 1'b1;
      end else begin
        word_count <= word_count + ONE_CNT;
      end
    end
  end

  // buffer is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (reset && capture && !full) begin
      mem[word_count[AW-1:0]] <= bus.data_bus;
    end
  end

  assign bus.rd_data    = mem[bus.rd_addr];
  assign bus.word_count = word_count;
  assign bus.overflow   = overflow;
  assign bus.done       = done_q;
  assign bus.proc_start = start_q;
  assign bus.busy       = busy_q;
endmodule
